// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the systolic array: fetches a weight tile, streams input vectors
// through the array and writes each result vector back over the shared data RAM port.
module systolic_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_N    = 4,
    parameter int ADDR_W     = 11,
    parameter int MEM_DEPTH  = 2048,
    parameter int ARRAY_LAT  = 7
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic                                    abort,
    input  logic [ADDR_W-1:0]                       cfg_w_base,
    input  logic [ADDR_W-1:0]                       cfg_a_base,
    input  logic [15:0]                             cfg_a_len,
    input  logic [ADDR_W-1:0]                       cfg_o_base,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    error,
    output logic                                    mem_ce,
    output logic                                    mem_we,
    output logic [3:0]                              mem_bwe,
    output logic [ADDR_W-1:0]                       mem_addr,
    output logic [31:0]                             mem_wdata,
    input  logic [31:0]                             mem_rdata,
    output logic                                    weights_load,
    output logic [ARRAY_N*ARRAY_N*DATA_WIDTH-1:0]   weight_data,
    output logic                                    in_valid,
    output logic [ARRAY_N*DATA_WIDTH-1:0]           input_data,
    input  logic [2*ARRAY_N*DATA_WIDTH-1:0]         output_data
);

    localparam int ROW_W = ARRAY_N * DATA_WIDTH;
    localparam int RW    = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;
    localparam int WW    = (ARRAY_LAT > 1) ? $clog2(ARRAY_LAT) : 1;
    localparam logic [31:0]       DEPTH_L  = 32'(MEM_DEPTH);
    localparam logic [RW-1:0]     R_LAST   = RW'(ARRAY_N - 1);
    localparam logic [WW-1:0]     W_LAST   = WW'(ARRAY_LAT - 1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        W_RD   = 4'd1,
        W_CAP  = 4'd2,
        W_LOAD = 4'd3,
        A_RD   = 4'd4,
        A_CAP  = 4'd5,
        A_WAIT = 4'd6,
        O_WR0  = 4'd7,
        O_WR1  = 4'd8,
        DONE   = 4'd9
    } state_t;

    state_t            state_r;
    logic [RW-1:0]     r_r;
    logic [15:0]       k_r;
    logic [WW-1:0]     wait_r;
    logic [ADDR_W-1:0] w_base_r;
    logic [ADDR_W-1:0] a_base_r;
    logic [ADDR_W-1:0] o_base_r;
    logic [15:0]       a_len_r;
    logic [ROW_W-1:0]  weights_r [ARRAY_N];
    logic [ROW_W-1:0]  hold_r;

    logic [31:0]       w_end_s;
    logic [31:0]       a_end_s;
    logic [31:0]       o_end_s;
    logic              cfg_ok_s;

    // Config range checks, widened to 32 bits so the sums cannot wrap
    always_comb begin
        w_end_s  = 32'(cfg_w_base) + 32'(ARRAY_N);
        a_end_s  = 32'(cfg_a_base) + 32'(cfg_a_len);
        o_end_s  = 32'(cfg_o_base) + {15'd0, cfg_a_len, 1'b0};
        cfg_ok_s = (cfg_a_len != 16'd0) && (w_end_s <= DEPTH_L) &&
                   (a_end_s <= DEPTH_L) && (o_end_s <= DEPTH_L);
    end

    // Flatten the weight rows onto the array bus
    always_comb begin
        weight_data = '0;
        for (int i = 0; i < ARRAY_N; i++) begin
            weight_data[i*ROW_W +: ROW_W] = weights_r[i];
        end
    end

    // Low result word goes straight through in O_WR0; high word comes from the hold register
    always_comb begin
        case (state_r)
            O_WR0:   mem_wdata = output_data[ROW_W-1:0];
            O_WR1:   mem_wdata = hold_r;
            default: mem_wdata = 32'd0;
        endcase
    end

    // Sequencer FSM; strobes are registered on entry to the state that owns them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            r_r          <= '0;
            k_r          <= 16'd0;
            wait_r       <= '0;
            w_base_r     <= '0;
            a_base_r     <= '0;
            o_base_r     <= '0;
            a_len_r      <= 16'd0;
            hold_r       <= '0;
            input_data   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            mem_ce       <= 1'b0;
            mem_we       <= 1'b0;
            mem_bwe      <= 4'h0;
            mem_addr     <= '0;
            weights_load <= 1'b0;
            in_valid     <= 1'b0;
            for (int i = 0; i < ARRAY_N; i++) begin
                weights_r[i] <= '0;
            end
        end else begin
            weights_load <= 1'b0;
            in_valid     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            mem_ce       <= 1'b0;
            mem_we       <= 1'b0;
            mem_bwe      <= 4'h0;
            mem_addr     <= '0;
            if (abort && (state_r != IDLE)) begin
                state_r <= IDLE;
                busy    <= 1'b0;
                r_r     <= '0;
                k_r     <= 16'd0;
                wait_r  <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        busy <= 1'b0;
                        r_r  <= '0;
                        k_r  <= 16'd0;
                        if (start) begin
                            w_base_r <= cfg_w_base;
                            a_base_r <= cfg_a_base;
                            o_base_r <= cfg_o_base;
                            a_len_r  <= cfg_a_len;
                            busy     <= 1'b1;
                            if (cfg_ok_s) begin
                                state_r  <= W_RD;
                                mem_ce   <= 1'b1;
                                mem_addr <= cfg_w_base;
                            end else begin
                                state_r <= DONE;
                                done    <= 1'b1;
                                error   <= 1'b1;
                            end
                        end
                    end
                    W_RD: begin
                        state_r <= W_CAP;
                    end
                    W_CAP: begin
                        weights_r[r_r] <= mem_rdata;
                        if (r_r == R_LAST) begin
                            r_r          <= '0;
                            state_r      <= W_LOAD;
                            weights_load <= 1'b1;
                        end else begin
                            r_r      <= r_r + RW'(1);
                            state_r  <= W_RD;
                            mem_ce   <= 1'b1;
                            mem_addr <= w_base_r + ADDR_W'(r_r) + ONE_A;
                        end
                    end
                    W_LOAD: begin
                        state_r  <= A_RD;
                        mem_ce   <= 1'b1;
                        mem_addr <= a_base_r + ADDR_W'(k_r);
                    end
                    A_RD: begin
                        state_r <= A_CAP;
                    end
                    A_CAP: begin
                        input_data <= mem_rdata;
                        in_valid   <= 1'b1;
                        wait_r     <= '0;
                        state_r    <= A_WAIT;
                    end
                    A_WAIT: begin
                        if (wait_r == W_LAST) begin
                            state_r  <= O_WR0;
                            mem_ce   <= 1'b1;
                            mem_we   <= 1'b1;
                            mem_bwe  <= 4'hF;
                            mem_addr <= o_base_r + ADDR_W'({k_r, 1'b0});
                        end else begin
                            wait_r <= wait_r + WW'(1);
                        end
                    end
                    O_WR0: begin
                        hold_r   <= output_data[2*ROW_W-1:ROW_W];
                        state_r  <= O_WR1;
                        mem_ce   <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_bwe  <= 4'hF;
                        mem_addr <= o_base_r + ADDR_W'({k_r, 1'b0}) + ONE_A;
                    end
                    O_WR1: begin
                        if (k_r == (a_len_r - 16'd1)) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            k_r      <= k_r + 16'd1;
                            state_r  <= A_RD;
                            mem_ce   <= 1'b1;
                            mem_addr <= a_base_r + ADDR_W'(k_r) + ONE_A;
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        k_r     <= 16'd0;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
